i2c_audio_rx: RTL and testbench

- Parametrised, system-clocked successor to the SCL-clocked I2C audio slave in the MFCC front end.
- Oversamples SCL/SDA on `clk` and detects START, repeated START and STOP.
- Accepts master-write transactions to its 7-bit address and assembles SAMPLE_WIDTH-bit, MSB-first samples, interleaved across NUM_CHANNELS.
- Presents each sample on a valid/ready stream into the MFCC pipeline. ACK/NACK reflects downstream backpressure.

---
 rtl/i2c_audio_rx.sv | 235 +++++++++++++++++++++++
 tb/tb_i2c_audio_rx.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_audio_rx.sv
// I2C master-write audio receiver: oversampled SCL/SDA with glitch filtering, START/STOP detection,
// samples delivered on a valid/ready stream. Define I2C_AUDIO_CLK_STRETCH_EN to stretch SCL instead of dropping.
module i2c_audio_rx #(
    parameter logic [6:0]   I2C_SLAVE_ADDRESS = 7'h45,
    parameter int unsigned  SAMPLE_WIDTH      = 16,
    parameter int unsigned  NUM_CHANNELS      = 2,
    parameter int unsigned  FILTER_LEN        = 3,
    localparam int unsigned CHAN_W            = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    scl_i,
    input  logic                    sda_i,
    output logic                    sda_o,
    output logic                    sda_t,
    output logic                    scl_o,
    output logic                    scl_t,
    output logic [SAMPLE_WIDTH-1:0] audio_data_o,
    output logic [CHAN_W-1:0]       audio_chan_o,
    output logic                    audio_valid_o,
    input  logic                    audio_ready_i,
    output logic                    overflow_o,
    output logic                    busy_o
);

    localparam int unsigned BYTES  = SAMPLE_WIDTH / 8;
    localparam int unsigned FLT_W  = 4;
    localparam int unsigned BIT_W  = 4;
    localparam int unsigned BYTE_W = 3;

    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK} state_t;

    logic [1:0]              scl_sync_q, sda_sync_q;
    logic                    scl_f_q, sda_f_q, scl_f_d, sda_f_d;
    logic [FLT_W-1:0]        scl_cnt_q, sda_cnt_q, scl_cnt_d, sda_cnt_d;
    logic                    scl_rise_q, scl_fall_q, start_q, stop_q;

    state_t                  state_q;
    logic [BIT_W-1:0]        bit_cnt_q;
    logic [BYTE_W-1:0]       byte_cnt_q;
    logic [7:0]              addr_sr_q;
    logic [SAMPLE_WIDTH-1:0] sample_sr_q;
    logic [CHAN_W-1:0]       chan_q, chan_inc_c;
    logic                    sda_t_q, busy_q, valid_q, overflow_q;
    logic [SAMPLE_WIDTH-1:0] data_q;
    logic [CHAN_W-1:0]       out_chan_q;
    logic                    out_free_c;
`ifdef I2C_AUDIO_CLK_STRETCH_EN
    logic                    scl_t_q, pend_q, scl_rel_q;
`endif

    // Glitch filter: a line flips only after FILTER_LEN consecutive samples of the new value
    always_comb begin
        scl_f_d   = scl_f_q;
        scl_cnt_d = '0;
        sda_f_d   = sda_f_q;
        sda_cnt_d = '0;
        if (scl_sync_q[1] != scl_f_q) begin
            if (scl_cnt_q == FLT_W'(FILTER_LEN - 1)) scl_f_d = scl_sync_q[1];
            else                                     scl_cnt_d = scl_cnt_q + FLT_W'(1);
        end
        if (sda_sync_q[1] != sda_f_q) begin
            if (sda_cnt_q == FLT_W'(FILTER_LEN - 1)) sda_f_d = sda_sync_q[1];
            else                                     sda_cnt_d = sda_cnt_q + FLT_W'(1);
        end
    end

    always_comb begin
        chan_inc_c = (chan_q == CHAN_W'(NUM_CHANNELS - 1)) ? '0 : chan_q + CHAN_W'(1);
        out_free_c = !valid_q || audio_ready_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_f_q    <= 1'b1;
            sda_f_q    <= 1'b1;
            scl_cnt_q  <= '0;
            sda_cnt_q  <= '0;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_f_q    <= scl_f_d;
            sda_f_q    <= sda_f_d;
            scl_cnt_q  <= scl_cnt_d;
            sda_cnt_q  <= sda_cnt_d;
            scl_rise_q <= ~scl_f_q & scl_f_d;
            scl_fall_q <= scl_f_q & ~scl_f_d;
            start_q    <= scl_f_q & scl_f_d & sda_f_q & ~sda_f_d;
            stop_q     <= scl_f_q & scl_f_d & ~sda_f_q & sda_f_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            addr_sr_q   <= '0;
            sample_sr_q <= '0;
            chan_q      <= '0;
            sda_t_q     <= 1'b1;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            data_q      <= '0;
            out_chan_q  <= '0;
`ifdef I2C_AUDIO_CLK_STRETCH_EN
            scl_t_q     <= 1'b1;
            pend_q      <= 1'b0;
            scl_rel_q   <= 1'b0;
`endif
        end else begin
            overflow_q <= 1'b0;
            if (valid_q && audio_ready_i) valid_q <= 1'b0;
`ifdef I2C_AUDIO_CLK_STRETCH_EN
            // SCL is released one cycle after the stretched sample is ACKed
            if (scl_rel_q) begin
                scl_t_q   <= 1'b1;
                scl_rel_q <= 1'b0;
            end
`endif
            if (start_q) begin
                state_q    <= ADDR;
                bit_cnt_q  <= '0;
                byte_cnt_q <= '0;
                chan_q     <= '0;
                sda_t_q    <= 1'b1;
                busy_q     <= 1'b0;
`ifdef I2C_AUDIO_CLK_STRETCH_EN
                pend_q     <= 1'b0;
                scl_t_q    <= 1'b1;
`endif
            end else if (stop_q) begin
                state_q <= IDLE;
                sda_t_q <= 1'b1;
                busy_q  <= 1'b0;
`ifdef I2C_AUDIO_CLK_STRETCH_EN
                pend_q  <= 1'b0;
                scl_t_q <= 1'b1;
`endif
            end else begin
                case (state_q)
                    ADDR: begin
                        if (scl_rise_q && bit_cnt_q != BIT_W'(8)) begin
                            addr_sr_q <= {addr_sr_q[6:0], sda_f_q};
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                        end else if (scl_fall_q && bit_cnt_q == BIT_W'(8)) begin
                            bit_cnt_q <= '0;
                            if (addr_sr_q == {I2C_SLAVE_ADDRESS, 1'b0}) begin
                                sda_t_q <= 1'b0;
                                busy_q  <= 1'b1;
                                state_q <= ADDR_ACK;
                            end else begin
                                state_q <= IDLE;
                            end
                        end
                    end
                    ADDR_ACK, DATA_ACK: begin
                        if (scl_fall_q) begin
                            sda_t_q <= 1'b1;
                            state_q <= DATA;
                        end
                    end
                    DATA: begin
`ifdef I2C_AUDIO_CLK_STRETCH_EN
                        if (pend_q) begin
                            if (out_free_c) begin
                                data_q     <= sample_sr_q;
                                out_chan_q <= chan_q;
                                valid_q    <= 1'b1;
                                chan_q     <= chan_inc_c;
                                byte_cnt_q <= '0;
                                sda_t_q    <= 1'b0;
                                pend_q     <= 1'b0;
                                scl_rel_q  <= 1'b1;
                                state_q    <= DATA_ACK;
                            end
                        end else
`endif
                        if (scl_rise_q && bit_cnt_q != BIT_W'(8)) begin
                            sample_sr_q <= {sample_sr_q[SAMPLE_WIDTH-2:0], sda_f_q};
                            bit_cnt_q   <= bit_cnt_q + BIT_W'(1);
                        end else if (scl_fall_q && bit_cnt_q == BIT_W'(8)) begin
                            bit_cnt_q <= '0;
                            if (byte_cnt_q != BYTE_W'(BYTES - 1)) begin
                                byte_cnt_q <= byte_cnt_q + BYTE_W'(1);
                                sda_t_q    <= 1'b0;
                                state_q    <= DATA_ACK;
                            end else if (out_free_c) begin
                                data_q     <= sample_sr_q;
                                out_chan_q <= chan_q;
                                valid_q    <= 1'b1;
                                chan_q     <= chan_inc_c;
                                byte_cnt_q <= '0;
                                sda_t_q    <= 1'b0;
                                state_q    <= DATA_ACK;
                            end else begin
`ifdef I2C_AUDIO_CLK_STRETCH_EN
                                pend_q  <= 1'b1;
                                scl_t_q <= 1'b0;
`else
                                overflow_q <= 1'b1;
                                busy_q     <= 1'b0;
                                state_q    <= IDLE;
`endif
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sda_o         = 1'b0;
    assign scl_o         = 1'b0;
    assign sda_t         = sda_t_q;
`ifdef I2C_AUDIO_CLK_STRETCH_EN
    assign scl_t         = scl_t_q;
`else
    assign scl_t         = 1'b1;
`endif
    assign audio_data_o  = data_q;
    assign audio_chan_o  = out_chan_q;
    assign audio_valid_o = valid_q;
    assign overflow_o    = overflow_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_i2c_audio_rx.sv
// Directed bench for i2c_audio_rx: bit-banged I2C master on a wired-AND bus, stream monitor, scoreboard checks.
module tb_i2c_audio_rx;

    localparam int Q = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        scl_m, sda_m, glitch;
    logic        audio_ready;
    logic        scl_bus, sda_bus;
    logic        sda_o, sda_t, scl_o, scl_t;
    logic [15:0] audio_data;
    logic        audio_chan;
    logic        audio_valid, overflow, busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] rx_data [0:63];
    logic        rx_chan [0:63];
    int rx_n = 0;
    int n_ovf = 0, n_valid = 0, n_busy = 0, n_sda_low = 0, n_scl_low = 0;

    assign scl_bus = scl_m & scl_t;
    assign sda_bus = sda_m & sda_t & ~glitch;

    i2c_audio_rx dut (
        .clk           (clk),
        .rst           (rst),
        .scl_i         (scl_bus),
        .sda_i         (sda_bus),
        .sda_o         (sda_o),
        .sda_t         (sda_t),
        .scl_o         (scl_o),
        .scl_t         (scl_t),
        .audio_data_o  (audio_data),
        .audio_chan_o  (audio_chan),
        .audio_valid_o (audio_valid),
        .audio_ready_i (audio_ready),
        .overflow_o    (overflow),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    // Stream and activity monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            if (audio_valid && audio_ready && rx_n < 64) begin
                rx_data[rx_n] = audio_data;
                rx_chan[rx_n] = audio_chan;
                rx_n = rx_n + 1;
            end
            if (overflow)    n_ovf     = n_ovf + 1;
            if (audio_valid) n_valid   = n_valid + 1;
            if (busy)        n_busy    = n_busy + 1;
            if (!sda_t)      n_sda_low = n_sda_low + 1;
            if (!scl_t)      n_scl_low = n_scl_low + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic scl_high();
        int t = 0;
        scl_m = 1'b1;
        while (!scl_bus && t < 5000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 5000) check("scl_release_timeout", 32'(scl_bus), 32'd1);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        wait_clks(Q);
        scl_high();
        wait_clks(Q);
        sda_m = 1'b0;
        wait_clks(Q);
        scl_m = 1'b0;
        wait_clks(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        wait_clks(Q);
        scl_high();
        wait_clks(Q);
        sda_m = 1'b1;
        wait_clks(Q);
    endtask

    task automatic i2c_bit(input logic b, input logic glitch_en, output logic s);
        sda_m = b;
        wait_clks(Q);
        scl_high();
        wait_clks(Q / 2);
        if (glitch_en) begin
            @(negedge clk) glitch = 1'b1;
            @(negedge clk) glitch = 1'b0;
        end
        wait_clks(Q / 2);
        s = sda_bus;
        wait_clks(Q);
        scl_m = 1'b0;
        wait_clks(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, input logic glitch_msb, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) i2c_bit(d[i], (i == 7) && glitch_msb, s);
        i2c_bit(1'b1, 1'b0, s);
        ack = ~s;
    endtask

    task automatic expect_rx(input string tag, input int idx, input logic [15:0] d, input logic c);
        check({tag, "_data"}, 32'(rx_data[idx]), 32'(d));
        check({tag, "_chan"}, 32'(rx_chan[idx]), 32'(c));
    endtask

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: got no completion, required completion within 90000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        logic a0, a1, a2, a3, a4;
        int rx0, ovf0, val0, busy0, low0;
`ifdef I2C_AUDIO_CLK_STRETCH_EN
        int scl0;
`endif
        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; glitch = 1'b0; audio_ready = 1'b1;
        wait_clks(3);
        #1;
        check("rst_sda_t",    32'(sda_t), 32'd1);
        check("rst_scl_t",    32'(scl_t), 32'd1);
        check("rst_sda_o",    32'(sda_o), 32'd0);
        check("rst_scl_o",    32'(scl_o), 32'd0);
        check("rst_valid",    32'(audio_valid), 32'd0);
        check("rst_data",     32'(audio_data), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_busy",     32'(busy), 32'd0);
        @(negedge clk) rst = 1'b0;
        wait_clks(20);

        // Two stereo samples with the sink always ready
        rx0 = rx_n;
        i2c_start();
        write_byte(8'h8A, 1'b0, a0);
        write_byte(8'h12, 1'b0, a1);
        write_byte(8'h34, 1'b0, a2);
        write_byte(8'h56, 1'b0, a3);
        write_byte(8'h78, 1'b0, a4);
        check("t1_busy_in_xfer", 32'(busy), 32'd1);
        i2c_stop();
        wait_clks(20);
        check("t1_ack_addr", 32'(a0), 32'd1);
        check("t1_ack_b0",   32'(a1), 32'd1);
        check("t1_ack_b1",   32'(a2), 32'd1);
        check("t1_ack_b2",   32'(a3), 32'd1);
        check("t1_ack_b3",   32'(a4), 32'd1);
        check("t1_rx_count", 32'(rx_n - rx0), 32'd2);
        expect_rx("t1_s0", rx0,     16'h1234, 1'b0);
        expect_rx("t1_s1", rx0 + 1, 16'h5678, 1'b1);
        check("t1_busy_after_stop", 32'(busy), 32'd0);

        // Wrong address, then a read: both NACKed, nothing driven
        val0 = n_valid; busy0 = n_busy; low0 = n_sda_low;
        i2c_start();
        write_byte(8'h88, 1'b0, a0);
        i2c_stop();
        i2c_start();
        write_byte(8'h8B, 1'b0, a1);
        i2c_stop();
        wait_clks(20);
        check("t2_ack_wrong_addr", 32'(a0), 32'd0);
        check("t2_ack_read",       32'(a1), 32'd0);
        check("t2_sda_low_cycles", 32'(n_sda_low - low0), 32'd0);
        check("t2_valid_cycles",   32'(n_valid - val0), 32'd0);
        check("t2_busy_cycles",    32'(n_busy - busy0), 32'd0);

        // Backpressure: the second sample meets a full output register
        audio_ready = 1'b0;
        rx0 = rx_n; ovf0 = n_ovf;
`ifdef I2C_AUDIO_CLK_STRETCH_EN
        scl0 = n_scl_low;
`endif
        i2c_start();
        write_byte(8'h8A, 1'b0, a0);
        write_byte(8'h12, 1'b0, a1);
        write_byte(8'h34, 1'b0, a2);
        write_byte(8'h56, 1'b0, a3);
`ifdef I2C_AUDIO_CLK_STRETCH_EN
        fork
            begin
                wait_clks(600);
                audio_ready = 1'b1;
            end
        join_none
        write_byte(8'h78, 1'b0, a4);
        i2c_stop();
        wait_clks(20);
        check("t3_ack_stretched", 32'(a4), 32'd1);
        check("t3_stretch_seen",  32'(n_scl_low > scl0), 32'd1);
        check("t3_overflow",      32'(n_ovf - ovf0), 32'd0);
        check("t3_rx_count",      32'(rx_n - rx0), 32'd2);
        expect_rx("t3_s0", rx0,     16'h1234, 1'b0);
        expect_rx("t3_s1", rx0 + 1, 16'h5678, 1'b1);
`else
        write_byte(8'h78, 1'b0, a4);
        i2c_stop();
        wait_clks(20);
        check("t3_ack_b1",      32'(a2), 32'd1);
        check("t3_ack_dropped", 32'(a4), 32'd0);
        check("t3_overflow",    32'(n_ovf - ovf0), 32'd1);
        check("t3_held_valid",  32'(audio_valid), 32'd1);
        check("t3_held_data",   32'(audio_data), 32'h1234);
        check("t3_held_chan",   32'(audio_chan), 32'd0);
        check("t3_busy",        32'(busy), 32'd0);
        @(negedge clk) audio_ready = 1'b1;
        wait_clks(5);
        check("t3_rx_count",    32'(rx_n - rx0), 32'd1);
        expect_rx("t3_s0", rx0, 16'h1234, 1'b0);
        check("t3_valid_clear", 32'(audio_valid), 32'd0);
`endif
        check("t3_ack_addr", 32'(a0), 32'd1);

        // Repeated START after a partial sample
        audio_ready = 1'b1;
        rx0 = rx_n;
        i2c_start();
        write_byte(8'h8A, 1'b0, a0);
        write_byte(8'h11, 1'b0, a1);
        write_byte(8'h22, 1'b0, a1);
        write_byte(8'hAB, 1'b0, a2);
        i2c_start();
        write_byte(8'h8A, 1'b0, a3);
        write_byte(8'h9A, 1'b0, a4);
        write_byte(8'hBC, 1'b0, a4);
        i2c_stop();
        wait_clks(20);
        check("t4_ack_partial", 32'(a2), 32'd1);
        check("t4_ack_readdr",  32'(a3), 32'd1);
        check("t4_rx_count",    32'(rx_n - rx0), 32'd2);
        expect_rx("t4_s0", rx0,     16'h1122, 1'b0);
        expect_rx("t4_s1", rx0 + 1, 16'h9ABC, 1'b0);

        // One-cycle SDA glitch while SCL is high must not look like START/STOP
        rx0 = rx_n;
        i2c_start();
        write_byte(8'h8A, 1'b0, a0);
        write_byte(8'hFF, 1'b1, a1);
        write_byte(8'h01, 1'b0, a2);
        check("t5_busy_kept", 32'(busy), 32'd1);
        i2c_stop();
        wait_clks(20);
        check("t5_ack", 32'(a2), 32'd1);
        check("t5_rx_count", 32'(rx_n - rx0), 32'd1);
        expect_rx("t5_s0", rx0, 16'hFF01, 1'b0);

        // Reset while the slave is driving an ACK with a sample pending
        audio_ready = 1'b0;
        i2c_start();
        write_byte(8'h8A, 1'b0, a0);
        write_byte(8'h12, 1'b0, a1);
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] d;
            d = 8'h34;
            i2c_bit(d[i], 1'b0, a2);
        end
        check("t6_sda_t_acking", 32'(sda_t), 32'd0);
        check("t6_valid_pre",    32'(audio_valid), 32'd1);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_sda_t",    32'(sda_t), 32'd1);
        check("t6_scl_t",    32'(scl_t), 32'd1);
        check("t6_valid",    32'(audio_valid), 32'd0);
        check("t6_data",     32'(audio_data), 32'd0);
        check("t6_chan",     32'(audio_chan), 32'd0);
        check("t6_busy",     32'(busy), 32'd0);
        check("t6_overflow", 32'(overflow), 32'd0);
        @(negedge clk) rst = 1'b0;
        scl_m = 1'b1;
        sda_m = 1'b1;
        wait_clks(30);
        check("t6_idle_sda_t", 32'(sda_t), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
